// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, registered syncs/blank
// and a once-per-frame tick at the start of vertical blank.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active_pixels,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic       VGA_CLK,
   output logic       pix_en,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   generate
      if (CLK_DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
         $error("vga_timing_gen: CLK_DIV must be >=2 and totals <=1024");
      end
   endgenerate

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_h;
   logic [9:0]       r_v;
   logic             r_act;
   logic             r_hs;
   logic             r_vs;
   logic             r_ft;

   logic             w_pix;
   logic             w_h_wrap;
   logic [9:0]       w_h_next;
   logic [9:0]       w_v_next;
   logic             w_act_next;
   logic             w_hs_next;
   logic             w_vs_next;
   logic             w_frame_edge;

   assign w_pix    = (r_div == DIV_LAST);
   assign w_h_wrap = (r_h == H_LAST);
   assign w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
   assign w_v_next = !w_h_wrap      ? r_v   :
                     (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;

   // Derived from the next counter values so x/y/syncs/blank land together.
   assign w_act_next   = (w_h_next < H_ACT) && (w_v_next < V_ACT);
   assign w_hs_next    = (w_h_next >= HS_FIRST && w_h_next <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
   assign w_vs_next    = (w_v_next >= VS_FIRST && w_v_next <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
   assign w_frame_edge = w_h_wrap && (r_v == V_ACT_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_h   <= H_LAST;
         r_v   <= V_LAST;
         r_act <= 1'b0;
         r_hs  <= ~SYNC_POL;
         r_vs  <= ~SYNC_POL;
         r_ft  <= 1'b0;
      end else begin
         r_div <= w_pix ? '0 : r_div + 1'b1;
         // Strobe lasts one clock since pix_en never repeats back-to-back.
         r_ft  <= w_pix && w_frame_edge;
         if (w_pix) begin
            r_h   <= w_h_next;
            r_v   <= w_v_next;
            r_act <= w_act_next;
            r_hs  <= w_hs_next;
            r_vs  <= w_vs_next;
         end
      end
   end

   assign x             = r_h;
   assign y             = r_v;
   assign active_pixels = r_act;
   assign VGA_BLANK_N   = r_act;
   assign VGA_HS        = r_hs;
   assign VGA_VS        = r_vs;
   assign VGA_SYNC_N    = 1'b0;
   assign VGA_CLK       = (r_div >= DIV_HALF);
   assign pix_en        = w_pix;
   assign frame_tick    = r_ft;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default-geometry DUT and a small CLK_DIV=3 / active-high
// sync DUT, each compared every clock against a pixel-index raster model.
module tb_vga_timing_gen;

   localparam int B_CD = 3, B_HA = 16, B_HFP = 4, B_HS = 6, B_HBP = 4;
   localparam int B_VA = 12, B_VFP = 2, B_VS = 2, B_VBP = 3;
   localparam int NCYC = 14000;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic act, blank_n, hs, vs, sync_n, vclk, pix, ft;
   } obs_t;

   logic       clk;
   logic       rst_n [2];
   logic [9:0] x0, y0, x1, y1;
   logic       act0, hs0, vs0, bn0, sn0, vclk0, pix0, ft0;
   logic       act1, hs1, vs1, bn1, sn1, vclk1, pix1, ft1;

   obs_t q0[$];
   obs_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   done = 0;
   bit   drained = 0;
   int   e [2];
   int   hold [2];
   int   ti [2];
   int   tgt [2][2];

   vga_timing_gen u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .x(x0), .y(y0), .active_pixels(act0),
      .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bn0), .VGA_SYNC_N(sn0),
      .VGA_CLK(vclk0), .pix_en(pix0), .frame_tick(ft0)
   );

   vga_timing_gen #(
      .CLK_DIV(B_CD), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP), .SYNC_POL(1'b1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .x(x1), .y(y1), .active_pixels(act1),
      .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1),
      .VGA_CLK(vclk1), .pix_en(pix1), .frame_tick(ft1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // e = clock edges seen since reset release; the raster position is just
   // the pixel index (pix_en count - 1) modulo the frame size.
   function automatic obs_t model(int ev, int cd, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp, bit pol);
      obs_t m;
      int ht, vt, n, p, ph, idx, hx, vy;
      ht  = ha + hfp + hsw + hbp;
      vt  = va + vfp + vsw + vbp;
      n   = ht * vt;
      p   = ev / cd;
      ph  = ev % cd;
      idx = (p + n - 1) % n;
      hx  = idx % ht;
      vy  = idx / ht;
      m.x       = 10'(hx);
      m.y       = 10'(vy);
      m.act     = (hx < ha) && (vy < va);
      m.blank_n = m.act;
      m.hs      = (hx >= ha + hfp && hx < ha + hfp + hsw) ? pol : ~pol;
      m.vs      = (vy >= va + vfp && vy < va + vfp + vsw) ? pol : ~pol;
      m.sync_n  = 1'b0;
      m.vclk    = (ph >= cd / 2);
      m.pix     = (ph == cd - 1);
      m.ft      = (ph == 0) && (p >= 1) && (idx == va * ht);
      return m;
   endfunction

   function automatic obs_t model_d(int d, int ev);
      if (d == 0) return model(ev, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      return model(ev, B_CD, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1);
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("x=%0d y=%0d act=%b blank_n=%b hs=%b vs=%b sync_n=%b vclk=%b pix=%b ft=%b",
                       o.x, o.y, o.act, o.blank_n, o.hs, o.vs, o.sync_n, o.vclk, o.pix, o.ft);
   endfunction

   // Monitor: pops one expectation per DUT each time outputs are presented.
   always @(negedge clk) begin
      obs_t got, want;
      if (q0.size() > 0) begin
         want = q0.pop_front();
         got  = {x0, y0, act0, bn0, hs0, vs0, sn0, vclk0, pix0, ft0};
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL dut0_outputs t=%0t got %s want %s", $time, fmt(got), fmt(want));
         end
      end
      if (q1.size() > 0) begin
         want = q1.pop_front();
         got  = {x1, y1, act1, bn1, hs1, vs1, sn1, vclk1, pix1, ft1};
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL dut1_outputs t=%0t got %s want %s", $time, fmt(got), fmt(want));
         end
      end
      if (done && !drained) begin
         drained = 1;
         n_cmp++;
         if (q0.size() + q1.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q0.size() + q1.size());
         end
      end
   end

   initial begin
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         e[d] = 0; hold[d] = 3; ti[d] = 0;
      end
      // Mid-run resets: dut0 inside the hsync pulse of line 1; dut1 in frame 4
      // while both HS and VS are asserted, then once more anywhere.
      tgt[0][0] = (800 + int'($urandom_range(656, 751)) + 1) * 2 + int'($urandom_range(0, 1));
      tgt[0][1] = (int'($urandom_range(0, 1599)) + 1) * 2 + int'($urandom_range(0, 1));
      tgt[1][0] = (3 * 570 + int'($urandom_range(14, 15)) * 30 + int'($urandom_range(20, 25)) + 1) * 3
                  + int'($urandom_range(0, 2));
      tgt[1][1] = int'($urandom_range(1, 1710));
      #1;
      rst_n[0] = 1'b0;
      rst_n[1] = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         for (int d = 0; d < 2; d++)
            if (rst_n[d]) e[d]++;
         #2;
         for (int d = 0; d < 2; d++) begin
            if (hold[d] > 0) begin
               rst_n[d] = 1'b0;
               e[d] = 0;
               hold[d]--;
            end else if (!rst_n[d]) begin
               rst_n[d] = 1'b1;
            end else if (ti[d] < 2 && e[d] == tgt[d][ti[d]]) begin
               rst_n[d] = 1'b0;
               e[d] = 0;
               hold[d] = int'($urandom_range(0, 3));
               ti[d]++;
            end
            if (d == 0) q0.push_back(model_d(0, e[0]));
            else        q1.push_back(model_d(1, e[1]));
         end
      end
      done = 1;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
